// File: rtl/rot_seq_if.sv
// rot_seq_if: handshake and data bundle between the control unit and rot_seq.
//   master modport (control unit): drives start, oprd, c_in, rlf_n_rrf, count;
//                                  observes busy, done, result, c_out.
//   slave modport (rot_seq):       the mirror image.
// Signals:
//   start      request, sampled only when the sequencer is idle
//   oprd       operand (WIDTH bits)
//   c_in       incoming carry
//   rlf_n_rrf  1 = rotate left through carry, 0 = rotate right through carry
//   count      number of single-bit steps (CNT_W bits)
//   busy       operation in progress
//   done       one-cycle pulse, result/c_out valid
//   result     final data (WIDTH bits)
//   c_out      final carry
interface rot_seq_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] oprd;
    logic             c_in;
    logic             rlf_n_rrf;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c_out;

    modport master (
        output start, oprd, c_in, rlf_n_rrf, count,
        input  busy, done, result, c_out
    );

    modport slave (
        input  start, oprd, c_in, rlf_n_rrf, count,
        output busy, done, result, c_out
    );
endinterface

// File: rtl/rot_seq.sv
// rot_seq: multi-position rotate-through-carry sequencer.
// Rotates the (WIDTH+1)-bit vector {C, data} by 'count' positions, one RLF/RRF
// step per clock, and reports the final data and carry with a start/busy/done
// handshake.
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous, active-high reset (aborts any operation, no done pulse)
//   rot_io  rot_seq_if slave modport (start/oprd/c_in/rlf_n_rrf/count in,
//           busy/done/result/c_out out)
// Build option:
//   ROT_SEQ_SINGLE_CYCLE_EN  when defined, RUN finishes in one cycle using a
//                            barrel rotate by (count mod (WIDTH+1)); results are
//                            identical to the iterative mode.
module rot_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic     clk,
    input  logic     rst,
    rot_seq_if.slave rot_io
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             c_out_q, c_out_d;

`ifdef ROT_SEQ_SINGLE_CYCLE_EN
    localparam int unsigned VecW = WIDTH + 1;

    logic [VecW-1:0]   rot_v;
    logic [2*VecW-1:0] dbl, dbl_l, dbl_r;
    logic [CNT_W-1:0]  amt;

    // Rotating the doubled vector lets one shift serve as a rotate: the upper
    // half of a left shift (or lower half of a right shift) is the rotation.
    always_comb begin
        amt   = CNT_W'(32'(rem_q) % VecW);
        dbl   = {carry_q, data_q, carry_q, data_q};
        dbl_l = dbl << amt;
        dbl_r = dbl >> amt;
        rot_v = dir_q ? dbl_l[2*VecW-1:VecW] : dbl_r[VecW-1:0];
    end
`else
    logic [WIDTH-1:0] step_d;
    logic             step_c;

    // One step through carry: RLF shifts C into bit 0, RRF into the MSB.
    always_comb begin
        if (dir_q) begin
            step_c = data_q[WIDTH-1];
            step_d = {data_q[WIDTH-2:0], carry_q};
        end else begin
            step_c = data_q[0];
            step_d = {carry_q, data_q[WIDTH-1:1]};
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        carry_d  = carry_q;
        rem_d    = rem_q;
        dir_d    = dir_q;
        result_d = result_q;
        c_out_d  = c_out_q;

        case (state_q)
            StIdle: begin
                if (rot_io.start) begin
                    data_d  = rot_io.oprd;
                    carry_d = rot_io.c_in;
                    rem_d   = rot_io.count;
                    dir_d   = rot_io.rlf_n_rrf;
                    state_d = StRun;
                end
            end
            StRun: begin
`ifdef ROT_SEQ_SINGLE_CYCLE_EN
                data_d   = rot_v[WIDTH-1:0];
                carry_d  = rot_v[WIDTH];
                rem_d    = '0;
                result_d = rot_v[WIDTH-1:0];
                c_out_d  = rot_v[WIDTH];
                state_d  = StDone;
`else
                if (rem_q == '0) begin
                    // Zero-step request: pass the latched operand straight out.
                    result_d = data_q;
                    c_out_d  = carry_q;
                    state_d  = StDone;
                end else begin
                    data_d  = step_d;
                    carry_d = step_c;
                    rem_d   = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        result_d = step_d;
                        c_out_d  = step_c;
                        state_d  = StDone;
                    end
                end
`endif
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            data_q   <= '0;
            carry_q  <= 1'b0;
            rem_q    <= '0;
            dir_q    <= 1'b0;
            result_q <= '0;
            c_out_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            carry_q  <= carry_d;
            rem_q    <= rem_d;
            dir_q    <= dir_d;
            result_q <= result_d;
            c_out_q  <= c_out_d;
        end
    end

    assign rot_io.busy   = (state_q == StRun);
    assign rot_io.done   = (state_q == StDone);
    assign rot_io.result = result_q;
    assign rot_io.c_out  = c_out_q;

endmodule
